// File: rtl/acc_datapath_pkg.sv
// Shared definitions for the accumulator datapath: word width, output FIFO depth,
// controller state encoding and strobe priority resolution.
package acc_datapath_pkg;

    localparam int unsigned WORD_W         = 16;
    localparam int unsigned OUT_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_OUT_WAIT,
        S_HALT
    } state_t;

    // Declaration order is the strobe priority, highest first.
    typedef enum logic [3:0] {
        OP_HLT,
        OP_READ,
        OP_WRITE,
        OP_OUT,
        OP_ARG,
        OP_ACC,
        OP_NAD,
        OP_SHL,
        OP_SHR,
        OP_NONE
    } op_t;

    // strobes = {hlt, read, write, out, arg, acc, nad, shl, shr}
    function automatic op_t pick_op(input logic [8:0] strobes);
        op_t op;
        if      (strobes[8]) op = OP_HLT;
        else if (strobes[7]) op = OP_READ;
        else if (strobes[6]) op = OP_WRITE;
        else if (strobes[5]) op = OP_OUT;
        else if (strobes[4]) op = OP_ARG;
        else if (strobes[3]) op = OP_ACC;
        else if (strobes[2]) op = OP_NAD;
        else if (strobes[1]) op = OP_SHL;
        else if (strobes[0]) op = OP_SHR;
        else                 op = OP_NONE;
        return op;
    endfunction

endpackage

// File: rtl/acc_datapath_out_fifo.sv
// Small circular FIFO buffering output-port words; head is presented
// combinationally and pointers wrap modulo DEPTH.
module out_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             full
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid   = (count != '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && valid;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/acc_datapath.sv
// Accumulator datapath with data-memory and output-port sequencing.
// Optional feature macro: ACC_DATAPATH_OUT_FIFO_EN (4-entry output FIFO instead of OUT_WAIT).
module acc_datapath
    import acc_datapath_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ctl_hlt,
    input  logic              ctl_arg,
    input  logic              ctl_nad,
    input  logic              ctl_shl,
    input  logic              ctl_shr,
    input  logic              ctl_acc,
    input  logic              ctl_out,
    input  logic              ctl_read,
    input  logic              ctl_write,
    input  logic [WORD_W-1:0] arg,
    output logic              alu_is_zero,
    output logic              stall,
    output logic [WORD_W-1:0] dmem_addr,
    output logic [WORD_W-1:0] dmem_wr_data,
    output logic              dmem_rd_en,
    output logic              dmem_wr_en,
    input  logic [WORD_W-1:0] dmem_rd_data,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted
);
    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] opnd;
    op_t               op;
    logic              accept;
    logic              out_pop;

    assign op          = pick_op({ctl_hlt, ctl_read, ctl_write, ctl_out,
                                  ctl_arg, ctl_acc, ctl_nad, ctl_shl, ctl_shr});
    assign out_pop     = out_valid && out_ready;
    assign alu_is_zero = (acc == '0);
    assign halted      = (state == S_HALT);

`ifdef ACC_DATAPATH_OUT_FIFO_EN
    logic              fifo_full;
    logic              fifo_push;
    logic [WORD_W-1:0] fifo_head;

    assign fifo_push = accept && (op == OP_OUT);
    assign out_data  = out_valid ? fifo_head : '0;

    out_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (acc),
        .pop       (out_pop),
        .head      (fifo_head),
        .valid     (out_valid),
        .full      (fifo_full)
    );
`endif

    always_comb begin
        stall     = 1'b0;
        accept    = 1'b0;
        state_nxt = state;
`ifdef ACC_DATAPATH_OUT_FIFO_EN
        stall  = (state == S_RD_WAIT) || ((state == S_IDLE) && fifo_full);
        // While full, only an output push that coincides with a pop gets through.
        accept = (state == S_IDLE) && (op != OP_NONE) &&
                 (!fifo_full || ((op == OP_OUT) && out_pop));
`else
        stall  = (state == S_RD_WAIT) || (state == S_OUT_WAIT);
        accept = (state == S_IDLE) && (op != OP_NONE);
`endif
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_HLT:  state_nxt = S_HALT;
                        OP_READ: state_nxt = S_RD_WAIT;
`ifndef ACC_DATAPATH_OUT_FIFO_EN
                        OP_OUT:  state_nxt = S_OUT_WAIT;
`endif
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
            // First RD_WAIT cycle carries the rd_en pulse; data lands in the second.
            S_RD_WAIT:  if (!dmem_rd_en) state_nxt = S_IDLE;
            S_OUT_WAIT: if (out_pop) state_nxt = S_IDLE;
            S_HALT:     state_nxt = S_HALT;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc          <= '0;
            opnd         <= '0;
            dmem_rd_en   <= 1'b0;
            dmem_wr_en   <= 1'b0;
            dmem_addr    <= '0;
            dmem_wr_data <= '0;
        end else begin
            dmem_rd_en <= accept && (op == OP_READ);
            dmem_wr_en <= accept && (op == OP_WRITE);
            if (accept && ((op == OP_READ) || (op == OP_WRITE))) dmem_addr <= arg;
            if (accept && (op == OP_WRITE)) dmem_wr_data <= acc;
            if ((state == S_RD_WAIT) && !dmem_rd_en) opnd <= dmem_rd_data;
            if (accept) begin
                case (op)
                    OP_ARG:  opnd <= arg;
                    OP_ACC:  acc  <= opnd;
                    OP_NAD:  acc  <= ~(acc & opnd);
                    OP_SHL:  acc  <= {acc[WORD_W-2:0], 1'b0};
                    OP_SHR:  acc  <= {1'b0, acc[WORD_W-1:1]};
                    default: ;
                endcase
            end
        end
    end

`ifndef ACC_DATAPATH_OUT_FIFO_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept && (op == OP_OUT)) begin
            out_valid <= 1'b1;
            out_data  <= acc;
        end else if (out_pop) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_acc_datapath.sv
// Self-checking bench for acc_datapath: directed scenarios plus randomized ALU/memory traffic
// against a behavioural model of the accumulator, operand register and data memory.
`timescale 1ns/1ps
module tb_acc_datapath;

    localparam logic [8:0] B_HLT   = 9'h100;
    localparam logic [8:0] B_READ  = 9'h080;
    localparam logic [8:0] B_WRITE = 9'h040;
    localparam logic [8:0] B_OUT   = 9'h020;
    localparam logic [8:0] B_ARG   = 9'h010;
    localparam logic [8:0] B_ACC   = 9'h008;
    localparam logic [8:0] B_NAD   = 9'h004;
    localparam logic [8:0] B_SHL   = 9'h002;
    localparam logic [8:0] B_SHR   = 9'h001;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  strb;
    logic [15:0] arg;
    logic        alu_is_zero, stall, dmem_rd_en, dmem_wr_en, out_valid, out_ready, halted;
    logic [15:0] dmem_addr, dmem_wr_data, dmem_rd_data, out_data;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    logic [15:0] mem [256];
    logic [255:0] mem_w = '0;

    logic [15:0] m_acc, m_opnd;
    logic [15:0] m_mem [256];
    logic [255:0] m_w;
    logic [15:0] fq [$];

    always #5 clk = ~clk;

    acc_datapath dut (
        .clk          (clk),
        .reset        (reset),
        .ctl_hlt      (strb[8]),
        .ctl_read     (strb[7]),
        .ctl_write    (strb[6]),
        .ctl_out      (strb[5]),
        .ctl_arg      (strb[4]),
        .ctl_acc      (strb[3]),
        .ctl_nad      (strb[2]),
        .ctl_shl      (strb[1]),
        .ctl_shr      (strb[0]),
        .arg          (arg),
        .alu_is_zero  (alu_is_zero),
        .stall        (stall),
        .dmem_addr    (dmem_addr),
        .dmem_wr_data (dmem_wr_data),
        .dmem_rd_en   (dmem_rd_en),
        .dmem_wr_en   (dmem_wr_en),
        .dmem_rd_data (dmem_rd_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .halted       (halted)
    );

    function automatic logic [15:0] init_f(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : {~a, a};
    endfunction

    // Synchronous memory: read data appears the cycle after dmem_rd_en.
    always @(posedge clk) begin
        if (dmem_wr_en) begin
            mem[dmem_addr[7:0]]   <= dmem_wr_data;
            mem_w[dmem_addr[7:0]] <= 1'b1;
        end
        if (dmem_rd_en)
            dmem_rd_data <= mem_w[dmem_addr[7:0]] ? mem[dmem_addr[7:0]] : init_f(dmem_addr[7:0]);
    end

    always @(posedge clk) begin
        if (reset && out_valid && out_ready) xfers++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [8:0] s, input logic [15:0] a);
        strb = s;
        arg  = a;
        step();
        strb = '0;
    endtask

    function automatic logic [15:0] model_mem(input logic [7:0] a);
        return m_w[a] ? m_mem[a] : init_f(a);
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, ".zero"},    16'(alu_is_zero), 16'h1);
        chk({tag, ".stall"},   16'(stall),       16'h0);
        chk({tag, ".halted"},  16'(halted),      16'h0);
        chk({tag, ".rd_en"},   16'(dmem_rd_en),  16'h0);
        chk({tag, ".wr_en"},   16'(dmem_wr_en),  16'h0);
        chk({tag, ".addr"},    dmem_addr,        16'h0);
        chk({tag, ".wr_data"}, dmem_wr_data,     16'h0);
        chk({tag, ".o_valid"}, 16'(out_valid),   16'h0);
        chk({tag, ".o_data"},  out_data,         16'h0);
    endtask

    task automatic alu(input logic [8:0] s, input logic [15:0] a);
        drive(s, a);
        if      ((s & B_ARG) != 0) m_opnd = a;
        else if ((s & B_ACC) != 0) m_acc  = m_opnd;
        else if ((s & B_NAD) != 0) m_acc  = ~(m_acc & m_opnd);
        else if ((s & B_SHL) != 0) m_acc  = m_acc << 1;
        else if ((s & B_SHR) != 0) m_acc  = m_acc >> 1;
        chk("alu.zero",  16'(alu_is_zero), 16'(m_acc == 16'h0));
        chk("alu.stall", 16'(stall),       16'h0);
    endtask

    task automatic do_write(input logic [15:0] a, input string tag);
        drive(B_WRITE, a);
        chk({tag, ".wr_en"},   16'(dmem_wr_en), 16'h1);
        chk({tag, ".wr_data"}, dmem_wr_data,    m_acc);
        chk({tag, ".addr"},    dmem_addr,       a);
        chk({tag, ".stall"},   16'(stall),      16'h0);
        m_mem[a[7:0]] = m_acc;
        m_w[a[7:0]]   = 1'b1;
        step();
        chk({tag, ".wr_end"},  16'(dmem_wr_en), 16'h0);
    endtask

    task automatic do_read(input logic [15:0] a, input string tag);
        drive(B_READ, a);
        chk({tag, ".rd_en"},  16'(dmem_rd_en), 16'h1);
        chk({tag, ".addr"},   dmem_addr,       a);
        chk({tag, ".stall1"}, 16'(stall),      16'h1);
        step();
        chk({tag, ".rd_end"}, 16'(dmem_rd_en), 16'h0);
        chk({tag, ".stall2"}, 16'(stall),      16'h1);
        step();
        chk({tag, ".stall3"}, 16'(stall),      16'h0);
        m_opnd = model_mem(a[7:0]);
    endtask

    initial begin
        int x0;
        reset = 1'b0; strb = '0; arg = '0; out_ready = 1'b0;
        m_acc = '0; m_opnd = '0; m_w = '0;
        #3;
        chk_reset("por");
        @(negedge clk); reset = 1'b1;

        // NAND of operand with itself
        alu(B_ARG, 16'h00F0); alu(B_ACC, 16'h0); alu(B_NAD, 16'h0);
        chk("nad.zero", 16'(alu_is_zero), 16'h0);
        do_write(16'h0040, "nad");

        // shifts, with the MSB falling off and the result reaching zero
        alu(B_ARG, 16'h8001); alu(B_ACC, 16'h0);
        alu(B_SHL, 16'h0); do_write(16'h0041, "shl");
        alu(B_SHR, 16'h0); alu(B_SHR, 16'h0);
        chk("shr.zero", 16'(alu_is_zero), 16'h1);

        // memory read into operand, then into accumulator
        do_read(16'h0010, "rd10");
        alu(B_ACC, 16'h0); do_write(16'h0042, "rdacc");

        // priority: read beats write/out/arg
        drive(B_READ | B_WRITE | B_OUT | B_ARG, 16'h0011);
        chk("pri_rd.rd_en", 16'(dmem_rd_en), 16'h1);
        chk("pri_rd.wr_en", 16'(dmem_wr_en), 16'h0);
        chk("pri_rd.o_val", 16'(out_valid),  16'h0);
        step(); step();
        m_opnd = model_mem(8'h11);
        // priority: write beats out/arg/acc
        drive(B_WRITE | B_OUT | B_ARG | B_ACC, 16'h0043);
        chk("pri_wr.wr_en", 16'(dmem_wr_en), 16'h1);
        chk("pri_wr.data",  dmem_wr_data,    m_acc);
        chk("pri_wr.o_val", 16'(out_valid),  16'h0);
        m_mem[8'h43] = m_acc; m_w[8'h43] = 1'b1;
        step();
        alu(B_ACC, 16'h0); do_write(16'h0044, "pri_chk");

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6)      alu(9'($urandom_range(1, 31)), 16'($urandom));
            else if (r < 8) do_write(16'($urandom), "rnd_wr");
            else            do_read(16'($urandom), "rnd_rd");
        end
        alu(B_ACC, 16'h0); do_write(16'h0045, "rnd_end");

        // output port
        alu(B_ARG, 16'h1234); alu(B_ACC, 16'h0);
        x0 = xfers;
`ifdef ACC_DATAPATH_OUT_FIFO_EN
        fq = {};
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin alu(B_ARG, 16'h1234 + 16'(k)); alu(B_ACC, 16'h0); end
            drive(B_OUT, 16'h0);
            fq.push_back(m_acc);
            chk("fifo.valid", 16'(out_valid), 16'h1);
            chk("fifo.head",  out_data,       fq[0]);
            chk("fifo.stall", 16'(stall),     16'(k == 3));
        end
        drive(B_OUT, 16'h0);
        chk("fifo.5th_stall", 16'(stall), 16'h1);
        chk("fifo.5th_head",  out_data,   fq[0]);
        out_ready = 1'b1;
        drive(B_OUT, 16'h0);
        out_ready = 1'b0;
        void'(fq.pop_front());
        fq.push_back(m_acc);
        chk("fifo.pp_stall", 16'(stall), 16'h1);
        chk("fifo.pp_head",  out_data,   fq[0]);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("fifo.drain_valid", 16'(out_valid), 16'h1);
            chk("fifo.drain_data",  out_data,       fq[0]);
            step();
            void'(fq.pop_front());
        end
        out_ready = 1'b0;
        chk("fifo.empty", 16'(out_valid), 16'h0);
        chk("fifo.xfers", 16'(xfers - x0), 16'h5);
`else
        drive(B_OUT | B_ARG, 16'h5555);
        for (int i = 0; i < 5; i++) begin
            chk("out.valid", 16'(out_valid), 16'h1);
            chk("out.data",  out_data,       16'h1234);
            chk("out.stall", 16'(stall),     16'h1);
            if (i == 2) drive(B_SHL, 16'h0);
            else        step();
        end
        out_ready = 1'b1;
        chk("out.rdy_valid", 16'(out_valid), 16'h1);
        step();
        out_ready = 1'b0;
        chk("out.done_valid", 16'(out_valid), 16'h0);
        chk("out.done_stall", 16'(stall),     16'h0);
        chk("out.xfers",      16'(xfers - x0), 16'h1);
        step();
        chk("out.xfers_hold", 16'(xfers - x0), 16'h1);
`endif
        do_write(16'h0046, "post_out");

        // halt beats write; later strobes ignored
        alu(B_ARG, 16'h00A5); alu(B_ACC, 16'h0); alu(B_ARG, 16'h0000);
        drive(B_HLT | B_WRITE, 16'h0077);
        chk("hlt.wr_en",  16'(dmem_wr_en), 16'h0);
        chk("hlt.halted", 16'(halted),     16'h1);
        chk("hlt.stall",  16'(stall),      16'h0);
        drive(B_ACC, 16'h0);
        chk("hlt.acc_ign", 16'(alu_is_zero), 16'h0);
        drive(B_ARG, 16'h0005);
        drive(B_WRITE, 16'h0003);
        chk("hlt.wr_ign", 16'(dmem_wr_en), 16'h0);
        drive(B_READ, 16'h0010);
        chk("hlt.rd_ign", 16'(dmem_rd_en), 16'h0);
        chk("hlt.held",   16'(halted),     16'h1);

        // reset in the middle of a read abandons the operand update
        reset = 1'b0; #2; chk_reset("rst_halt");
        @(negedge clk); reset = 1'b1;
        m_acc = '0; m_opnd = '0;
        drive(B_READ, 16'h0010);
        chk("rst_rd.rd_en", 16'(dmem_rd_en), 16'h1);
        reset = 1'b0; #2; chk_reset("rst_rd");
        @(negedge clk); reset = 1'b1;
        step(); step();
        alu(B_ACC, 16'h0);
        chk("rst_rd.opnd", 16'(alu_is_zero), 16'h1);

        // reset in the middle of an output handshake drops valid without transfer
        alu(B_ARG, 16'h1234); alu(B_ACC, 16'h0);
        drive(B_OUT, 16'h0);
        chk("rst_out.valid", 16'(out_valid), 16'h1);
        x0 = xfers;
        reset = 1'b0; #2; chk_reset("rst_out");
        @(negedge clk); reset = 1'b1;
        out_ready = 1'b1; step(); step(); out_ready = 1'b0;
        chk("rst_out.xfers", 16'(xfers - x0), 16'h0);
        chk("rst_out.valid2", 16'(out_valid), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
